// File: rtl/hpdmc_fmlarb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_fmlarb_pkg
// Description : Shared FML burst/data constants and index types for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package hpdmc_fmlarb_pkg;

  localparam int FML_BURST = 4;
  localparam int FML_DW    = 64;
  localparam int FML_SW    = 8;
  localparam int IDX_W     = 3;

  typedef logic [IDX_W-1:0] midx_t;
  typedef logic [2:0]       wcnt_t;

endpackage
`default_nettype wire

// File: rtl/hpdmc_fmlarb_rrpick.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_fmlarb_rrpick
// Description : Combinational round-robin picker; first requester after i_last.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_fmlarb_rrpick
  import hpdmc_fmlarb_pkg::*;
#(
  parameter int NMASTERS = 4
) (
  input  logic [NMASTERS-1:0] i_req,
  input  midx_t               i_last,
  output midx_t               o_pick,
  output logic                o_any
);

  int w_best;
  int w_dist;

  // Distance 0 is the master right after i_last; i_last itself is searched last.
  always_comb begin
    o_pick = '0;
    o_any  = 1'b0;
    w_best = NMASTERS;
    w_dist = 0;
    for (int j = 0; j < NMASTERS; j++) begin
      w_dist = (j + 2 * NMASTERS - 1 - int'(i_last)) % NMASTERS;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_pick = midx_t'(j);
        o_any  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdmc_fmlarb.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_fmlarb
// Description : Round-robin arbiter sharing one FML 4x64 port among N masters.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_fmlarb
  import hpdmc_fmlarb_pkg::*;
#(
  parameter int SDRAM_DEPTH = 26,
  parameter int NMASTERS    = 4
) (
  input  logic                            i_sys_clk,
  input  logic                            i_sys_rst,
  input  logic [NMASTERS*SDRAM_DEPTH-1:0] i_m_adr,
  input  logic [NMASTERS-1:0]             i_m_stb,
  input  logic [NMASTERS-1:0]             i_m_we,
  output logic [NMASTERS-1:0]             o_m_eack,
  input  logic [NMASTERS*FML_SW-1:0]      i_m_sel,
  input  logic [NMASTERS*FML_DW-1:0]      i_m_di,
  output logic [FML_DW-1:0]               o_m_do,
  output logic [SDRAM_DEPTH-1:0]          o_s_adr,
  output logic                            o_s_stb,
  output logic                            o_s_we,
  input  logic                            i_s_eack,
  output logic [FML_SW-1:0]               o_s_sel,
  output logic [FML_DW-1:0]               o_s_di,
  input  logic [FML_DW-1:0]               i_s_do
);

  midx_t r_owner;
  logic  r_owner_valid;
  midx_t r_rr_last;
  midx_t r_wowner;
  wcnt_t r_wcnt;

  logic  w_own_stb;
  logic  w_ack;
  logic  w_rearb;
  midx_t w_pick_last;
  midx_t w_pick;
  logic  w_any;

  always_comb begin
    o_s_adr   = i_m_adr[0 +: SDRAM_DEPTH];
    o_s_we    = i_m_we[0];
    w_own_stb = i_m_stb[0];
    for (int i = 1; i < NMASTERS; i++) begin
      if (r_owner == midx_t'(i)) begin
        o_s_adr   = i_m_adr[i*SDRAM_DEPTH +: SDRAM_DEPTH];
        o_s_we    = i_m_we[i];
        w_own_stb = i_m_stb[i];
      end
    end
  end

  // Holding stb off until the last beat keeps the next burst's data from overlapping.
  assign o_s_stb     = r_owner_valid & w_own_stb & (r_wcnt <= 3'd1);
  assign w_ack       = i_s_eack & o_s_stb;
  assign w_rearb     = ~r_owner_valid | w_ack | ~w_own_stb;
  assign w_pick_last = w_ack ? r_owner : r_rr_last;
  assign o_m_do      = i_s_do;

  always_comb begin
    o_m_eack = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      o_m_eack[i] = w_ack & (r_owner == midx_t'(i));
    end
  end

  always_comb begin
    o_s_sel = '0;
    o_s_di  = '0;
    if (r_wcnt != '0) begin
      for (int i = 0; i < NMASTERS; i++) begin
        if (r_wowner == midx_t'(i)) begin
          o_s_sel = i_m_sel[i*FML_SW +: FML_SW];
          o_s_di  = i_m_di[i*FML_DW +: FML_DW];
        end
      end
    end
  end

  hpdmc_fmlarb_rrpick #(
    .NMASTERS (NMASTERS)
  ) u_rrpick (
    .i_req  (i_m_stb),
    .i_last (w_pick_last),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_rr_last     <= midx_t'(NMASTERS - 1);
      r_wowner      <= '0;
      r_wcnt        <= '0;
    end else begin
      if (w_rearb) begin
        r_owner       <= w_pick;
        r_owner_valid <= w_any;
      end
      if (w_ack) begin
        r_rr_last <= r_owner;
      end
      if (w_ack & o_s_we) begin
        r_wowner <= r_owner;
        r_wcnt   <= wcnt_t'(FML_BURST);
      end else if (r_wcnt != '0) begin
        r_wcnt <= r_wcnt - 3'd1;
      end
    end
  end

endmodule
`default_nettype wire
